// File: rtl/rx_pkg.sv
// Shared types and constants for the receive-side framing logic.
package rx_pkg;

   typedef enum logic [1:0] {
      HUNT,
      LEN,
      PAYLOAD,
      CHK
   } rx_state_t;

   localparam logic [15:0] DEFAULT_SYNC = 16'hEB90;
   localparam int          CSUM_W       = 8;

endpackage

// File: rtl/bit_to_byte.sv
// MSB-first serial-to-byte assembler; byte_done pulses the cycle after the 8th bit.
module bit_to_byte (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bit_in,
   input  logic       bit_vld,
   input  logic       clear,
   output logic [7:0] data_byte,
   output logic       byte_done
);

   logic [6:0] shift_q;
   logic [2:0] cnt_q;

   // The counter wraps after a completed byte, so the next bit starts a fresh byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q   <= '0;
         cnt_q     <= '0;
         data_byte <= '0;
         byte_done <= 1'b0;
      end else begin
         byte_done <= 1'b0;
         if (clear) begin
            shift_q <= '0;
            cnt_q   <= '0;
         end else if (bit_vld) begin
            shift_q <= {shift_q[5:0], bit_in};
            cnt_q   <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               data_byte <= {shift_q, bit_in};
               byte_done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/frame_deframer.sv
// Frame deframer: sync hunt, length byte, payload bytes and additive checksum byte,
// with a mid-frame inactivity timeout.
module frame_deframer
   import rx_pkg::*;
#(
   parameter logic [15:0] SYNC_WORD   = DEFAULT_SYNC,
   parameter int          MAX_LEN     = 64,
   parameter int          TIMEOUT_CYC = 1024
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bit_in,
   input  logic       bit_vld,
   output logic [7:0] byte_out,
   output logic       byte_vld,
   output logic       sof,
   output logic       frame_done,
   output logic       crc_ok,
   output logic       frame_err,
   output logic       busy
);

   localparam int          TW        = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

   rx_state_t         state_q, state_d;
   logic [14:0]       sync_q, sync_d;
   logic [15:0]       sync_next;
   logic [7:0]        byte_cnt_q, byte_cnt_d;
   logic [CSUM_W-1:0] sum_q, sum_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic              first_q, first_d;
   logic              crc_q, crc_d;
   logic [7:0]        hold_q, hold_d;
   logic              tmo_err_q, tmo_err_d;
   logic              ovf_err, go_hunt, clear;
   logic [7:0]        data_byte;
   logic              byte_done;

   bit_to_byte u_b2b (
      .clk       (clk),
      .rst_n     (rst_n),
      .bit_in    (bit_in),
      .bit_vld   (bit_vld),
      .clear     (clear),
      .data_byte (data_byte),
      .byte_done (byte_done)
   );

   assign sync_next = {sync_q, bit_in};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= HUNT;
         sync_q     <= '0;
         byte_cnt_q <= '0;
         sum_q      <= '0;
         tmo_q      <= '0;
         first_q    <= 1'b0;
         crc_q      <= 1'b0;
         hold_q     <= '0;
         tmo_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         byte_cnt_q <= byte_cnt_d;
         sum_q      <= sum_d;
         tmo_q      <= tmo_d;
         first_q    <= first_d;
         crc_q      <= crc_d;
         hold_q     <= hold_d;
         tmo_err_q  <= tmo_err_d;
      end
   end

   // Byte-level pulses come straight off the registered byte_done, giving one-cycle
   // latency; the state itself moves one cycle later, while the assembler keeps counting.
   always_comb begin
      state_d    = state_q;
      sync_d     = sync_q;
      byte_cnt_d = byte_cnt_q;
      sum_d      = sum_q;
      tmo_d      = '0;
      first_d    = first_q;
      crc_d      = crc_q;
      hold_d     = hold_q;
      tmo_err_d  = 1'b0;
      ovf_err    = 1'b0;
      go_hunt    = 1'b0;
      clear      = 1'b0;
      byte_vld   = 1'b0;
      sof        = 1'b0;
      frame_done = 1'b0;

      unique case (state_q)
         HUNT: begin
            clear = 1'b1;
            if (bit_vld) begin
               sync_d = sync_next[14:0];
               if (sync_next == SYNC_WORD) state_d = LEN;
            end
         end
         default: begin
            tmo_d = bit_vld ? '0 : tmo_q + TW'(1);
            if (!bit_vld && tmo_q == TMO_LAST) begin
               tmo_err_d = 1'b1;
               go_hunt   = 1'b1;
            end else if (byte_done) begin
               unique case (state_q)
                  LEN: begin
                     sum_d = data_byte;
                     if (data_byte > MAX_LEN_B) begin
                        ovf_err = 1'b1;
                        go_hunt = 1'b1;
                     end else if (data_byte == 8'd0) begin
                        state_d = CHK;
                     end else begin
                        state_d    = PAYLOAD;
                        byte_cnt_d = data_byte;
                        first_d    = 1'b1;
                     end
                  end
                  PAYLOAD: begin
                     byte_vld   = 1'b1;
                     sof        = first_q;
                     first_d    = 1'b0;
                     hold_d     = data_byte;
                     sum_d      = sum_q + data_byte;
                     byte_cnt_d = byte_cnt_q - 8'd1;
                     if (byte_cnt_q == 8'd1) state_d = CHK;
                  end
                  default: begin
                     frame_done = 1'b1;
                     crc_d      = (data_byte == sum_q);
                     go_hunt    = 1'b1;
                  end
               endcase
            end
         end
      endcase

      // A bit landing in the same cycle as the return to HUNT is the first fresh sync bit.
      if (go_hunt) begin
         state_d    = HUNT;
         tmo_d      = '0;
         byte_cnt_d = '0;
         sum_d      = '0;
         first_d    = 1'b0;
         sync_d     = bit_vld ? {14'd0, bit_in} : '0;
      end
   end

   assign byte_out  = byte_vld ? data_byte : hold_q;
   assign crc_ok    = frame_done ? crc_d : crc_q;
   assign frame_err = ovf_err | tmo_err_q;
   assign busy      = (state_q != HUNT);

endmodule

// File: tb/tb_frame_deframer.sv
// Randomized and directed bench for frame_deframer against a bit-stream parsing model.
module tb_frame_deframer;

   localparam logic [15:0] SYNC = 16'hEB90;
   localparam int MAXL = 64;
   localparam int TMO  = 1024;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       bit_in = 1'b0;
   logic       bit_vld = 1'b0;
   logic [7:0] byte_out;
   logic       byte_vld, sof, frame_done, crc_ok, frame_err, busy;

   frame_deframer #(.SYNC_WORD(SYNC), .MAX_LEN(MAXL), .TIMEOUT_CYC(TMO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bit_in     (bit_in),
      .bit_vld    (bit_vld),
      .byte_out   (byte_out),
      .byte_vld   (byte_vld),
      .sof        (sof),
      .frame_done (frame_done),
      .crc_ok     (crc_ok),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int nByte = 0, nSof = 0, nDone = 0, nErr = 0, nCrcOk = 0;

   // Reference model state: sliding sync window, then the raw bits of the current frame.
   logic [15:0] mWin;
   bit          mInFrame;
   bit          mBits[$];
   int          mIdle;
   logic [3:0]  expPulse;
   logic [7:0]  expByte, mLast;
   logic        expCrc, mCrcHeld;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] mByte(input int k);
      logic [7:0] v = '0;
      for (int i = 0; i < 8; i++) v = {v[6:0], mBits[k*8+i]};
      return v;
   endfunction

   task automatic modelLeave();
      mInFrame = 1'b0;
      mWin     = '0;
      mBits.delete();
      mIdle    = 0;
   endtask

   task automatic modelReset();
      modelLeave();
      expPulse = '0;
      expByte  = '0;
      expCrc   = 1'b0;
      mLast    = '0;
      mCrcHeld = 1'b0;
   endtask

   // Pulse order: {byte_vld, sof, frame_done, frame_err}, predicted for the next cycle.
   task automatic modelStep(input logic v, input logic b);
      int n, k, len;
      logic [7:0] s;
      expPulse = '0;
      if (!mInFrame) begin
         if (v) begin
            mWin = {mWin[14:0], b};
            if (mWin == SYNC) begin
               mInFrame = 1'b1;
               mBits.delete();
               mIdle = 0;
            end
         end
      end else if (v) begin
         mIdle = 0;
         mBits.push_back(b);
         n = mBits.size();
         if (n % 8 == 0) begin
            len = int'(mByte(0));
            k   = n / 8 - 1;
            if (n == 8 && len > MAXL) begin
               expPulse = 4'b0001;
               modelLeave();
            end else if (n > 8 && k <= len) begin
               expPulse = {1'b1, (k == 1), 2'b00};
               expByte  = mByte(k);
               mLast    = expByte;
            end else if (n > 8) begin
               s = '0;
               for (int i = 0; i <= len; i++) s += mByte(i);
               expCrc   = (s == mByte(k));
               mCrcHeld = expCrc;
               expPulse = 4'b0010;
               modelLeave();
            end
         end
      end else if (mIdle == TMO - 1) begin
         expPulse = 4'b0001;
         modelLeave();
      end else begin
         mIdle++;
      end
   endtask

   task automatic applyStimulus(input logic v, input logic b);
      logic [3:0] act;
      bit_vld = v;
      bit_in  = b;
      modelStep(v, b);
      @(posedge clk);
      #1;
      act = {byte_vld, sof, frame_done, frame_err};
      if (act != 4'b0000 || expPulse != 4'b0000) begin
         checkOutput("pulses", 32'(act), 32'(expPulse));
         if (expPulse[3]) checkOutput("byte_out", 32'(byte_out), 32'(expByte));
         if (expPulse[1]) checkOutput("crc_ok", 32'(crc_ok), 32'(expCrc));
      end else begin
         checkOutput("busy_crc_hold", 32'({busy, crc_ok, byte_out}), 32'({mInFrame, mCrcHeld, mLast}));
      end
      nByte  += int'(byte_vld);
      nSof   += int'(sof);
      nDone  += int'(frame_done);
      nErr   += int'(frame_err);
      nCrcOk += int'(frame_done & crc_ok);
   endtask

   task automatic sendBit(input logic b, input int gap);
      applyStimulus(1'b1, b);
      repeat (gap) applyStimulus(1'b0, 1'($urandom_range(0, 1)));
   endtask

   task automatic sendBytes(input logic [7:0] q[$], input int gap);
      foreach (q[j])
         for (int i = 7; i >= 0; i--) sendBit(q[j][i], gap);
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0);
   endtask

   task automatic doReset();
      @(posedge clk);
      #2;
      rst_n   = 1'b0;
      bit_vld = 1'b0;
      #1;
      checkOutput("reset_outs", 32'({byte_out, byte_vld, sof, frame_done, crc_ok, frame_err, busy}), 32'd0);
      modelReset();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Compares event counters accumulated over one directed scenario.
   task automatic checkCounts(input string tag, input int b0, input int s0, input int d0,
                              input int e0, input int c0,
                              input int eb, input int es, input int ed, input int ee, input int ec);
      checkOutput({tag, "_bytes"}, 32'(nByte - b0), 32'(eb));
      checkOutput({tag, "_sof"},   32'(nSof - s0),  32'(es));
      checkOutput({tag, "_done"},  32'(nDone - d0), 32'(ed));
      checkOutput({tag, "_err"},   32'(nErr - e0),  32'(ee));
      checkOutput({tag, "_crcok"}, 32'(nCrcOk - c0), 32'(ec));
   endtask

   initial begin
      int b0, s0, d0, e0, c0;
      logic [7:0] q[$];
      logic [7:0] sum;
      int len, gap;

      modelReset();
      doReset();

      b0 = nByte; s0 = nSof; d0 = nDone; e0 = nErr; c0 = nCrcOk;
      sendBytes('{8'hEB, 8'h90, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09}, 255);
      idle(4);
      checkCounts("good", b0, s0, d0, e0, c0, 3, 1, 1, 0, 1);

      b0 = nByte; s0 = nSof; d0 = nDone; e0 = nErr; c0 = nCrcOk;
      sendBytes('{8'hEB, 8'h90, 8'h03, 8'h01, 8'h02, 8'h03, 8'h0A}, 3);
      idle(4);
      checkCounts("badck", b0, s0, d0, e0, c0, 3, 1, 1, 0, 0);

      b0 = nByte; s0 = nSof; d0 = nDone; e0 = nErr; c0 = nCrcOk;
      sendBytes('{8'hEB, 8'h90, 8'h50}, 2);
      idle(4);
      sendBytes('{8'hEB, 8'h90, 8'h01, 8'hAA, 8'hAB}, 2);
      idle(4);
      checkCounts("ovf", b0, s0, d0, e0, c0, 1, 1, 1, 1, 1);

      b0 = nByte; s0 = nSof; d0 = nDone; e0 = nErr; c0 = nCrcOk;
      sendBytes('{8'hEB, 8'h90, 8'h04, 8'h11}, 1);
      for (int i = 3; i >= 0; i--) sendBit(i[0], 1);
      idle(1100);
      sendBytes('{8'hEB, 8'h90, 8'h01, 8'hAA, 8'hAB}, 1);
      idle(4);
      checkCounts("tmo", b0, s0, d0, e0, c0, 2, 2, 1, 1, 1);
      checkOutput("tmo_last_byte", 32'(byte_out), 32'h0000_00AA);

      b0 = nByte; s0 = nSof; d0 = nDone; e0 = nErr; c0 = nCrcOk;
      sendBytes('{8'h75, 8'h75, 8'h75, 8'h75, 8'hEB, 8'h90, 8'h00, 8'h00}, 2);
      idle(4);
      checkCounts("zlen", b0, s0, d0, e0, c0, 0, 0, 1, 0, 1);

      sendBytes('{8'hEB, 8'h90, 8'h05, 8'h11, 8'h22}, 1);
      sendBit(1'b1, 0);
      doReset();
      b0 = nByte; s0 = nSof; d0 = nDone; e0 = nErr; c0 = nCrcOk;
      sendBytes('{8'hEB, 8'h90, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09}, 1);
      idle(4);
      checkCounts("postrst", b0, s0, d0, e0, c0, 3, 1, 1, 0, 1);

      // Back-to-back frames with a bit on every clock.
      b0 = nByte; s0 = nSof; d0 = nDone; e0 = nErr; c0 = nCrcOk;
      sendBytes('{8'hEB, 8'h90, 8'h02, 8'h10, 8'h20, 8'h32,
                  8'hEB, 8'h90, 8'h01, 8'h7F, 8'h80}, 0);
      idle(4);
      checkCounts("b2b", b0, s0, d0, e0, c0, 3, 2, 2, 0, 2);

      for (int f = 0; f < 25; f++) begin
         q.delete();
         repeat ($urandom_range(0, 2)) q.push_back(8'($urandom));
         len = $urandom_range(0, MAXL + 8);
         q.push_back(8'hEB);
         q.push_back(8'h90);
         q.push_back(8'(len));
         sum = 8'(len);
         for (int i = 0; i < len; i++) begin
            q.push_back(8'($urandom));
            sum += q[q.size()-1];
         end
         q.push_back(($urandom_range(0, 3) == 0) ? sum ^ 8'h01 : sum);
         if ($urandom_range(0, 7) == 0) q = q[0:q.size()-2];
         gap = $urandom_range(0, 3);
         sendBytes(q, gap);
         if ($urandom_range(0, 7) == 0) idle(1100);
         else idle($urandom_range(0, 20));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
